// File: rtl/dds_pkg.sv
// Shared DDS definitions: waveform mode encodings, per-word sideband and full-scale helper.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_TABLE  = 2'b00,
    MODE_QSINE  = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_SAW    = 2'b11
  } mode_e;

  // Sideband that travels with each accepted phase word down the pipeline.
  typedef struct packed {
    mode_e mode;
    logic  neg;
    logic  wrap;
  } side_t;

  // Words allowed between acceptance and leaving the output buffer.
  localparam int unsigned CREDITS = 2;

  // Largest positive two's-complement value for a given sample width.
  function automatic int unsigned full_scale(input int unsigned dw);
    return (32'd1 << (dw - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/wave_out_fifo.sv
// Two-entry output buffer; head register drives the output directly.
module wave_out_fifo #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_occ;
  logic         w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head;
  assign o_occ   = r_occ;
  assign w_pop   = o_valid & i_ready;

  // Head/tail shift with simultaneous push and pop support.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      if (w_pop && (r_occ == 2'd2)) r_head <= r_tail;
      if (i_push) begin
        if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) r_head <= i_data;
        else                                              r_tail <= i_data;
      end
      r_occ <= r_occ + 2'(i_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/wave_reader.sv
// Phase-to-sample reader: address generation, RAM read, waveform shaping, credit-limited output.
module wave_reader
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic              phase_wrap,
  input  logic              phase_valid,
  output logic              phase_ready,
  input  logic [1:0]        mode,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_sync,
  output logic              sample_valid,
  input  logic              sample_ready
);

  localparam logic [DATA_W-1:0] FULL_SCALE = DATA_W'(full_scale(DATA_W));

  logic              w_accept;
  mode_e             w_mode;
  logic [1:0]        w_q;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic              w_reads;
  logic              w_neg;
  logic [DATA_W-1:0] w_direct;
  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_sample;
  logic [2:0]        w_credits;
  logic [1:0]        w_occ;
  logic [DATA_W:0]   w_fifo_data;
  logic              w_unused_phase;

  logic              r_s1_v;
  side_t             r_s1_side;
  logic [DATA_W-1:0] r_s1_direct;
  logic              r_s2_v;
  side_t             r_s2_side;
  logic [DATA_W-1:0] r_s2_direct;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;

  assign w_unused_phase = ^phase_in;
  assign w_credits      = 3'(r_s1_v) + 3'(r_s2_v) + 3'(w_occ);
  assign phase_ready    = ~rst & (w_credits < 3'(CREDITS));
  assign w_accept       = phase_valid & phase_ready;
  assign mem_rd         = r_mem_rd;
  assign mem_addr       = r_mem_addr;

  // Decode the incoming word: RAM address, quadrant sign, or a RAM-free sample.
  always_comb begin
    w_mode   = mode_e'(mode);
    w_q      = phase_in[PHASE_W-1 -: 2];
    w_idx    = phase_in[PHASE_W-3 -: ADDR_W];
    w_addr   = '0;
    w_reads  = 1'b0;
    w_neg    = 1'b0;
    w_direct = '0;
    case (w_mode)
      MODE_TABLE: begin
        w_reads = 1'b1;
        w_addr  = phase_in[PHASE_W-1 -: ADDR_W];
      end
      MODE_QSINE: begin
        w_reads = 1'b1;
        w_addr  = w_q[0] ? ~w_idx : w_idx;
        w_neg   = w_q[1];
      end
      MODE_SQUARE: w_direct = phase_in[PHASE_W-1] ? -FULL_SCALE : FULL_SCALE;
      MODE_SAW:    w_direct = {~phase_in[PHASE_W-1], phase_in[PHASE_W-2 -: DATA_W-1]};
      default:     w_direct = '0;
    endcase
  end

  // S1 drives the RAM port; S2 waits for the RAM data alongside its sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v      <= 1'b0;
      r_s1_side   <= '{mode: MODE_TABLE, neg: 1'b0, wrap: 1'b0};
      r_s1_direct <= '0;
      r_s2_v      <= 1'b0;
      r_s2_side   <= '{mode: MODE_TABLE, neg: 1'b0, wrap: 1'b0};
      r_s2_direct <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_s1_v   <= w_accept;
      r_mem_rd <= w_accept & w_reads;
      if (w_accept & w_reads) r_mem_addr <= w_addr;
      if (w_accept) begin
        r_s1_side   <= '{mode: w_mode, neg: w_neg, wrap: phase_wrap};
        r_s1_direct <= w_direct;
      end
      r_s2_v      <= r_s1_v;
      r_s2_side   <= r_s1_side;
      r_s2_direct <= r_s1_direct;
    end
  end

  // S3 shapes the RAM word (magnitude and sign) or passes the precomputed sample.
  always_comb begin
    w_mag    = {1'b0, mem_data[DATA_W-2:0]};
    w_sample = r_s2_direct;
    case (r_s2_side.mode)
      MODE_TABLE: w_sample = mem_data;
      MODE_QSINE: w_sample = r_s2_side.neg ? -w_mag : w_mag;
      default:    w_sample = r_s2_direct;
    endcase
  end

  wave_out_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s2_v),
    .i_data  ({r_s2_side.wrap, w_sample}),
    .o_valid (sample_valid),
    .i_ready (sample_ready),
    .o_data  (w_fifo_data),
    .o_occ   (w_occ)
  );

  assign sample_out  = w_fifo_data[DATA_W-1:0];
  assign sample_sync = w_fifo_data[DATA_W];

endmodule

// File: tb/tb_wave_reader.sv
// Directed bench for wave_reader with a one-cycle-latency RAM returning its own address.
module tb_wave_reader;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PHASE_W-1:0] phase_in = '0;
  logic               phase_wrap = 1'b0;
  logic               phase_valid = 1'b0;
  logic               phase_ready;
  logic [1:0]         mode = 2'b00;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_data = '0;
  logic [DATA_W-1:0]  sample_out;
  logic               sample_sync;
  logic               sample_valid;
  logic               sample_ready = 1'b1;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  // RAM model: data equals the address read on the previous cycle.
  always @(posedge clk) if (mem_rd) mem_data <= {2'b00, mem_addr};

  wave_reader #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_in     (phase_in),
    .phase_wrap   (phase_wrap),
    .phase_valid  (phase_valid),
    .phase_ready  (phase_ready),
    .mode         (mode),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .sample_out   (sample_out),
    .sample_sync  (sample_sync),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst         = 1'b1;
    phase_valid = 1'b0;
    #1;
    check({tag, "_ready_in_rst"}, 32'(phase_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_out"}, 32'(sample_out), 32'd0);
    check({tag, "_sync"}, 32'(sample_sync), 32'd0);
    check({tag, "_ready"}, 32'(phase_ready), 32'd1);
  endtask

  // One word through an empty pipeline: RAM port at N+1, sample exactly at N+3.
  task automatic run_one(input string tag, input logic [1:0] m, input logic [15:0] p,
                         input logic w, input logic exp_rd, input logic [9:0] exp_addr,
                         input logic [11:0] exp_s);
    mode         = m;
    phase_in     = p;
    phase_wrap   = w;
    phase_valid  = 1'b1;
    sample_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(phase_ready), 32'd1);
    tick();
    phase_valid = 1'b0;
    phase_wrap  = 1'b0;
    check({tag, "_rd"}, 32'(mem_rd), 32'(exp_rd));
    if (exp_rd) check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, "_v1"}, 32'(sample_valid), 32'd0);
    tick();
    check({tag, "_v2"}, 32'(sample_valid), 32'd0);
    tick();
    check({tag, "_v3"}, 32'(sample_valid), 32'd1);
    check({tag, "_data"}, 32'(sample_out), 32'(exp_s));
    check({tag, "_sync"}, 32'(sample_sync), 32'(w));
    tick();
    check({tag, "_nodup"}, 32'(sample_valid), 32'd0);
  endtask

  // Stream n table-mode words (sample value start+k), stalling the sink for 'stall' cycles.
  task automatic stream(input string tag, input int n, input int start, input int stall,
                        input int sync_idx, output int early_acc);
    int wi;
    int oi;
    wi        = 0;
    oi        = 0;
    early_acc = 0;
    mode      = 2'b00;
    for (int cyc = 0; cyc < 300 && oi < n; cyc++) begin
      sample_ready = (cyc >= stall);
      phase_valid  = (wi < n);
      phase_in     = PHASE_W'((start + wi) << 6);
      phase_wrap   = (wi == sync_idx);
      #1;
      if (!sample_ready && sample_valid)
        check({tag, "_hold"}, 32'(sample_out), 32'(start));
      if (sample_valid && sample_ready) begin
        check({tag, "_data"}, 32'(sample_out), 32'(start + oi));
        check({tag, "_sync"}, 32'(sample_sync), 32'(oi == sync_idx));
        oi++;
      end
      if (phase_valid && phase_ready) begin
        wi++;
        if (cyc < stall) early_acc++;
      end
      tick();
    end
    phase_valid  = 1'b0;
    phase_wrap   = 1'b0;
    sample_ready = 1'b1;
    check({tag, "_count"}, 32'(oi), 32'(n));
  endtask

  initial begin
    int acc;
    tick();
    do_reset("init");

    run_one("tbl",   2'b00, 16'h1230, 1'b0, 1'b1, 10'h048, 12'h048);
    run_one("qs_q1", 2'b01, 16'h4010, 1'b0, 1'b1, 10'h3FE, 12'h3FE);
    run_one("qs_q2", 2'b01, 16'h8010, 1'b1, 1'b1, 10'h001, 12'hFFF);
    run_one("qs_q3", 2'b01, 16'hC000, 1'b0, 1'b1, 10'h3FF, 12'hC01);
    run_one("qs_q0", 2'b01, 16'h0040, 1'b0, 1'b1, 10'h004, 12'h004);
    run_one("sq_pos", 2'b10, 16'h7FFF, 1'b0, 1'b0, 10'h000, 12'h7FF);
    run_one("sq_neg", 2'b10, 16'h8000, 1'b0, 1'b0, 10'h000, 12'h801);
    run_one("saw_lo", 2'b11, 16'h0000, 1'b0, 1'b0, 10'h000, 12'h800);
    run_one("saw_hi", 2'b11, 16'hFFF0, 1'b1, 1'b0, 10'h000, 12'h7FF);

    stream("bp", 10, 1, 6, 4, acc);
    check("bp_early_accepts", 32'(acc), 32'd2);
    stream("run", 10, 11, 0, 4, acc);

    // Reset with two words still in the pipeline.
    sample_ready = 1'b0;
    mode         = 2'b00;
    phase_in     = 16'h00C0;
    phase_valid  = 1'b1;
    tick();
    tick();
    phase_valid = 1'b0;
    check("rstA_ready_low", 32'(phase_ready), 32'd0);
    do_reset("rstA");
    run_one("rstA_post", 2'b00, 16'h0140, 1'b0, 1'b1, 10'h005, 12'h005);

    // Reset with the output buffer full.
    sample_ready = 1'b0;
    phase_in     = 16'h00C0;
    phase_valid  = 1'b1;
    tick();
    tick();
    phase_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rstB_full_valid", 32'(sample_valid), 32'd1);
    check("rstB_full_ready", 32'(phase_ready), 32'd0);
    do_reset("rstB");
    run_one("rstB_post", 2'b00, 16'h0180, 1'b1, 1'b1, 10'h006, 12'h006);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
